ps2_tx_bank: RTL
================

PS2_TX_BANK -- requirements
Module: ps2_tx_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning the number of independent PS/2 device-side transmit channels (1..8).
REQ-002 SHALL have parameter FIFO_BITS, default 3, meaning the log2 of the per-channel FIFO depth (depth = 2**FIFO_BITS bytes).
REQ-003 SHALL have parameter PS2DIV, default 100, meaning the divider setting; clk_ps2 = clk_sys/((PS2DIV+1)*2).
REQ-004 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port wr_data, input, 8*CHANNELS bits: channel n's byte is in bits [8n+7:8n].
REQ-007 SHALL have port wr_en, input, CHANNELS bits: a one-cycle push strobe per channel.
REQ-008 SHALL have port host_inhibit, input, CHANNELS bits: asynchronous; high means the host holds the PS/2 clock low.
REQ-009 SHALL have port ovf_clr, input, CHANNELS bits: clears the sticky overflow flag.
REQ-010 SHALL have port ps2_clk, output, CHANNELS bits: the emulated PS/2 clock line.
REQ-011 SHALL have port ps2_data, output, CHANNELS bits: the emulated PS/2 data line.
REQ-012 SHALL have port fifo_full, output, CHANNELS bits: FIFO occupancy equals depth.
REQ-013 SHALL have port overflow, output, CHANNELS bits: sticky flag, set when a push is dropped.
REQ-014 SHALL have port busy, output, CHANNELS bits: a frame is in progress or the FIFO is non-empty.

Function
REQ-015 SHALL run one shared divider, counting 0..PS2DIV, that toggles clk_ps2 at the count wrap; "tick" is a one-clk_sys pulse on each clk_ps2 rising edge.
REQ-016 SHALL accept a push when wr_en[n]=1 and fifo_full[n]=0 at that edge; the data becomes readable on the next cycle; there is no bypass path.
REQ-017 SHALL drop a push that arrives while the FIFO is full, leave the FIFO unchanged and set overflow[n] on the next cycle; if set and ovf_clr occur in the same cycle, set wins.
REQ-018 SHALL use pointer arithmetic modulo depth, with a separate FIFO_BITS+1 occupancy count; a simultaneous push and pop on a non-full FIFO leaves the count unchanged.
REQ-019 SHALL implement per-channel states IDLE, START, DATA (bit index 0..7), PARITY, STOP and HOLD; state advances only on a tick.
REQ-020 SHALL, in IDLE, on a tick with the FIFO non-empty and the synchronised inhibit low: pop into tx_hold, drive ps2_data=0 and go to START.
REQ-021 SHALL send DATA LSB first, one bit per tick, then odd parity (1 when tx_hold has an even number of ones), then STOP with ps2_data=1, then return to IDLE on the next tick.
REQ-022 SHALL drive ps2_clk = clk_ps2 OR (state==IDLE OR state==HOLD); ps2_data SHALL be 1 in IDLE and HOLD.
REQ-023 SHALL pass host_inhibit through a two-flop synchroniser before use (2-cycle latency).
REQ-024 SHALL, when the synchronised inhibit rises in START, DATA or PARITY: enter HOLD immediately (without waiting for a tick) and keep tx_hold.
REQ-025 SHALL, while in HOLD, wait until the synchronised inhibit is low, then on the next tick restart START with the same tx_hold; the FIFO is not popped again.
REQ-026 SHALL let a frame that has reached STOP complete regardless of inhibit.
REQ-027 SHALL keep channels fully independent apart from the shared divider; frames on different channels may overlap.

Reset
REQ-028 SHALL, while reset=1, asynchronously force: divider=0, clk_ps2=0, all states IDLE, FIFOs empty, ps2_clk=1, ps2_data=1, fifo_full=0, overflow=0, busy=0.
REQ-029 SHALL discard a frame in progress and all FIFO contents when reset is asserted mid-frame; after release the lines stay idle-high until the next push.

Structure
REQ-030 SHALL place the state encoding enum and the frame-length constant (11 bits) in the shared package ps2_pkg.
REQ-031 SHALL instantiate one sub-module, ps2_tx_chan (FIFO plus state machine), CHANNELS times via generate; the top level holds the divider only.

Verification
REQ-032 SHALL cover: PS2DIV=3, push 0x1C on ch0 -> ps2_data sampled at ps2_clk falling edges = 0,0,0,1,1,1,0,0,0,0,1; busy falls after STOP.
REQ-033 SHALL cover: push 0x00 -> parity bit = 1; push 0xFF -> parity bit = 1; push 0x01 -> parity bit = 0.
REQ-034 SHALL cover: FIFO_BITS=3, 9 pushes in consecutive cycles with inhibit high -> fifo_full=1 after the 8th, overflow=1 after the 9th; after release the 8 bytes are sent in order and the 9th is absent.
REQ-035 SHALL cover: inhibit asserted during DATA bit 4 of 0xA5 -> HOLD with both lines high; after release the full 0xA5 frame is resent and the FIFO count is not decremented twice.
REQ-036 SHALL cover: reset pulse mid-frame on ch1 while ch0 is idle -> all outputs return to reset values within the same cycle; a later push of 0x55 transmits correctly.
REQ-037 SHALL cover: CHANNELS=2, simultaneous pushes 0x12 (ch0) and 0x34 (ch1) -> both frames start on the same tick with correct bits and no cross-talk.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-side transmit bank.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_HOLD   = 3'd5
    } tx_state_t;

    // Start + 8 data + parity + stop.
    localparam int FRAME_BITS = 11;

    // Odd parity bit: 1 when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_chan.sv
// One PS/2 device-side transmit channel: byte FIFO, inhibit synchroniser and
// frame state machine clocked by the shared divider tick.
module ps2_tx_chan
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tick,
    input  logic       clk_ps2,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       host_inhibit,
    input  logic       ovf_clr,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       fifo_full,
    output logic       overflow,
    output logic       busy
);

    localparam int DEPTH = 2 ** FIFO_BITS;
    localparam logic [FIFO_BITS:0] DEPTH_CNT = (FIFO_BITS + 1)'(DEPTH);

    logic [7:0]           mem [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr;
    logic [FIFO_BITS-1:0] rd_ptr;
    logic [FIFO_BITS:0]   count;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    logic                 inh_meta;
    logic                 inh_sync;

    tx_state_t            state;
    tx_state_t            next_state;
    logic [2:0]           bit_idx;
    logic [2:0]           next_bit_idx;
    logic [7:0]           tx_hold;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign push       = wr_en & ~fifo_full;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            inh_meta <= 1'b0;
            inh_sync <= 1'b0;
        end else begin
            inh_meta <= host_inhibit;
            inh_sync <= inh_meta;
        end
    end

    // Storage has no reset; emptiness is defined by the count alone.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            tx_hold <= '0;
        end else begin
            state   <= next_state;
            bit_idx <= next_bit_idx;
            if (pop) begin
                tx_hold <= mem[rd_ptr];
            end
        end
    end

    // Inhibit aborts START/DATA/PARITY at once; HOLD resends tx_hold unchanged.
    always_comb begin
        next_state   = state;
        next_bit_idx = bit_idx;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick && !fifo_empty && !inh_sync) begin
                    pop        = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_START: begin
                if (inh_sync) begin
                    next_state = ST_HOLD;
                end else if (tick) begin
                    next_state   = ST_DATA;
                    next_bit_idx = 3'd0;
                end
            end
            ST_DATA: begin
                if (inh_sync) begin
                    next_state = ST_HOLD;
                end else if (tick) begin
                    if (bit_idx == 3'd7) begin
                        next_state = ST_PARITY;
                    end else begin
                        next_bit_idx = bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (inh_sync) begin
                    next_state = ST_HOLD;
                end else if (tick) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    next_state = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (tick && !inh_sync) begin
                    next_state = ST_START;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ps2_clk  = clk_ps2;
        ps2_data = 1'b1;
        busy     = (state != ST_IDLE) || !fifo_empty;
        case (state)
            ST_IDLE, ST_HOLD: begin
                ps2_clk  = 1'b1;
                ps2_data = 1'b1;
            end
            ST_START:  ps2_data = 1'b0;
            ST_DATA:   ps2_data = tx_hold[bit_idx];
            ST_PARITY: ps2_data = odd_parity(tx_hold);
            ST_STOP:   ps2_data = 1'b1;
            default:   ps2_data = 1'b1;
        endcase
    end

endmodule

// File: rtl/ps2_tx_bank.sv
// Bank of independent PS/2 transmit channels sharing one clock divider.
module ps2_tx_bank
    import ps2_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [8*CHANNELS-1:0] wr_data,
    input  logic [CHANNELS-1:0]   wr_en,
    input  logic [CHANNELS-1:0]   host_inhibit,
    input  logic [CHANNELS-1:0]   ovf_clr,
    output logic [CHANNELS-1:0]   ps2_clk,
    output logic [CHANNELS-1:0]   ps2_data,
    output logic [CHANNELS-1:0]   fifo_full,
    output logic [CHANNELS-1:0]   overflow,
    output logic [CHANNELS-1:0]   busy
);

    localparam int DIV_W = (PS2DIV < 1) ? 1 : $clog2(PS2DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PS2DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             clk_ps2;
    logic             tick;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            clk_ps2 <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            clk_ps2 <= ~clk_ps2;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // High in the cycle whose closing edge raises clk_ps2, so state and clock move together.
    assign tick = (div_cnt == DIV_LAST) && !clk_ps2;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        ps2_tx_chan #(
            .FIFO_BITS(FIFO_BITS)
        ) u_chan (
            .clk_sys     (clk_sys),
            .reset       (reset),
            .tick        (tick),
            .clk_ps2     (clk_ps2),
            .wr_data     (wr_data[8*g +: 8]),
            .wr_en       (wr_en[g]),
            .host_inhibit(host_inhibit[g]),
            .ovf_clr     (ovf_clr[g]),
            .ps2_clk     (ps2_clk[g]),
            .ps2_data    (ps2_data[g]),
            .fifo_full   (fifo_full[g]),
            .overflow    (overflow[g]),
            .busy        (busy[g])
        );
    end

endmodule
